// File: rtl/gpu_fb_pkg.sv
// gpu_fb_pkg: shared types, defaults and helpers
// for the framebuffer streamer.
package gpu_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN
  } fb_state_t;

  localparam int FB_DATA_WIDTH = 64;
  localparam int FB_DEPTH      = 600;
  localparam int FB_ADDR_WIDTH = 10;

  localparam logic [63:0] FB_CLEAR_VALUE =
    64'h0020_0020_0020_0020;

  // Merge helper works on a wide container;
  // callers cast in and truncate out.
  localparam int FB_MERGE_W  = 512;
  localparam int FB_MERGE_BE = FB_MERGE_W / 8;

  function automatic logic [FB_MERGE_W-1:0] bytes_merge(
    input logic [FB_MERGE_W-1:0]  old_w,
    input logic [FB_MERGE_W-1:0]  new_w,
    input logic [FB_MERGE_BE-1:0] be
  );
    logic [FB_MERGE_W-1:0] r;
    r = old_w;
    for (int i = 0; i < FB_MERGE_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_fb_skid_fifo.sv
// gpu_fb_skid_fifo: 2-entry valid/ready FIFO
// for scan-out words, exposes its occupancy.
module gpu_fb_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & ((cnt != 2'd2) | pop);

  assign out_valid = (cnt != 2'd0);
  assign out_data  = rptr ? slot1 : slot0;
  assign occ       = cnt;

  // slot storage and pointers
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      if (push) begin
        if (wptr) slot1 <= in_data;
        else      slot0 <= in_data;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/gpu_framebuffer_stream.sv
// gpu_framebuffer_stream: character framebuffer
// with CPU port, clear engine and scan-out.
module gpu_framebuffer_stream
  import gpu_fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_DEPTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE =
    DATA_WIDTH'(FB_CLEAR_VALUE)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [63:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    cpu_write,
  input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_err,
  input  logic                    clear_req,
  input  logic                    scan_start,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   scan_data,
  output logic [ADDR_WIDTH-1:0]   scan_index,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic                    scan_last,
  output logic                    frame_done
);

  localparam int PW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fb_state_t state_q;
  fb_state_t state_d;
  logic      clearing;
  logic      scanning;

  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] merged;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_done;
  logic                  issue;

  logic                  rd_v;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_last;

  logic          f_valid;
  logic [PW-1:0] f_data;
  logic [1:0]    f_occ;
  logic          f_last;
  logic          pop;

  // full 64-bit bounds check before truncation
  assign in_range = cpu_addr < 64'(DEPTH);
  assign addr_i   = cpu_addr[ADDR_WIDTH-1:0];

  assign merged = DATA_WIDTH'(bytes_merge(
    FB_MERGE_W'(mem[addr_i]),
    FB_MERGE_W'(cpu_wdata),
    FB_MERGE_BE'(cpu_byte_en)));

  assign pop = f_valid & scan_ready;

  // a word leaving the head this edge frees its
  // slot, which keeps one word per cycle
  assign issue = scanning & ~fetch_done &
    (({1'b0, f_occ} + 3'(rd_v)) < (3'd2 + 3'(pop)));

  // state register
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req)       state_d = CLEAR;
        else if (scan_start) state_d = SCAN;
      end
      CLEAR: if (clr_cnt == LAST) state_d = IDLE;
      SCAN:  if (pop && f_last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    busy     = 1'b0;
    clearing = 1'b0;
    scanning = 1'b0;
    unique case (1'b1)
      (state_q == CLEAR): begin
        busy     = 1'b1;
        clearing = 1'b1;
      end
      (state_q == SCAN): begin
        busy     = 1'b1;
        scanning = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM write port, clear beats the CPU
  always_ff @(negedge clock) begin
    if (clearing) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (cpu_write && in_range) begin
      mem[addr_i] <= merged;
    end
  end

  // CPU load data and reject pulse
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_rdata <= in_range ? mem[addr_i] : '0;
      cpu_err   <= cpu_write & (~in_range | clearing);
    end
  end

  // clear engine index
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
    end
  end

  // scan fetch, registered read and frame pulse
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_idx  <= '0;
      fetch_done <= 1'b0;
      rd_v       <= 1'b0;
      rd_data    <= '0;
      rd_idx     <= '0;
      rd_last    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_v       <= issue;
      frame_done <= scanning & pop & f_last;
      if (issue) begin
        rd_data <= mem[fetch_idx];
        rd_idx  <= fetch_idx;
        rd_last <= (fetch_idx == LAST);
        if (fetch_idx == LAST) fetch_done <= 1'b1;
        else fetch_idx <= fetch_idx + 1'b1;
      end
      if (!scanning) begin
        fetch_idx  <= '0;
        fetch_done <= 1'b0;
      end
    end
  end

  gpu_fb_skid_fifo #(
    .W(PW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rd_v),
    .in_data   ({rd_data, rd_idx, rd_last}),
    .out_valid (f_valid),
    .out_data  (f_data),
    .out_ready (scan_ready),
    .occ       (f_occ)
  );

  assign {scan_data, scan_index, f_last} = f_data;
  assign scan_valid = f_valid;
  assign scan_last  = f_valid & f_last;

endmodule

// File: tb/tb_gpu_framebuffer_stream.sv
// tb_gpu_framebuffer_stream: directed checks of
// CPU port, clear engine and scan-out.
module tb_gpu_framebuffer_stream;

  localparam logic [63:0] CLR = 64'h0020_0020_0020_0020;

  logic        clock;
  logic        reset_n;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_byte_en;
  logic [63:0] cpu_rdata;
  logic        cpu_err;
  logic        clear_req;
  logic        scan_start;
  logic        busy;
  logic [63:0] scan_data;
  logic [9:0]  scan_index;
  logic        scan_valid;
  logic        scan_ready;
  logic        scan_last;
  logic        frame_done;

  int checks;
  int errors;

  gpu_framebuffer_stream dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_write   (cpu_write),
    .cpu_byte_en (cpu_byte_en),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .clear_req   (clear_req),
    .scan_start  (scan_start),
    .busy        (busy),
    .scan_data   (scan_data),
    .scan_index  (scan_index),
    .scan_valid  (scan_valid),
    .scan_ready  (scan_ready),
    .scan_last   (scan_last),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 64'd0);
    chk({tag, "_err"}, 64'(cpu_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(scan_valid), 64'd0);
    chk({tag, "_last"}, 64'(scan_last), 64'd0);
    chk({tag, "_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_index"}, 64'(scan_index), 64'd0);
    chk({tag, "_data"}, scan_data, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int lat;
    int bad;
    int bad2;
    int vbad;
    int exp_i;
    int held;
    int fd_bad;

    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_write   = 1'b0;
    cpu_byte_en = 8'hFF;
    clear_req   = 1'b0;
    scan_start  = 1'b0;
    scan_ready  = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock);

    // byte-enable store and read-before-write
    cpu_write = 1'b1;
    cpu_addr  = 64'd5;
    cpu_wdata = 64'h1111_2222_3333_4444;
    @(posedge clock);
    cpu_wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    cpu_byte_en = 8'h0F;
    @(posedge clock);
    chk("rbw_old", cpu_rdata, 64'h1111_2222_3333_4444);
    cpu_write   = 1'b0;
    cpu_byte_en = 8'hFF;
    @(posedge clock);
    chk("be_merge", cpu_rdata, 64'h1111_2222_FFFF_FFFF);

    // bounds
    cpu_write = 1'b1;
    cpu_addr  = 64'd599;
    cpu_wdata = 64'hDEAD_BEEF_0000_0257;
    @(posedge clock);
    chk("err_inrange", 64'(cpu_err), 64'd0);
    cpu_addr  = 64'd600;
    cpu_wdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clock);
    chk("oob_err", 64'(cpu_err), 64'd1);
    chk("oob_rdata", cpu_rdata, 64'd0);
    cpu_addr = 64'h1_0000_0257;
    @(posedge clock);
    chk("oob_hi_err", 64'(cpu_err), 64'd1);
    chk("oob_hi_rdata", cpu_rdata, 64'd0);
    cpu_write = 1'b0;
    cpu_addr  = 64'd599;
    @(posedge clock);
    chk("oob_pulse", 64'(cpu_err), 64'd0);
    chk("addr599", cpu_rdata, 64'hDEAD_BEEF_0000_0257);

    // clear, with a competing scan_start
    clear_req  = 1'b1;
    scan_start = 1'b1;
    @(posedge clock);
    clear_req   = 1'b0;
    scan_start  = 1'b0;
    cpu_write   = 1'b1;
    cpu_addr    = 64'd10;
    cpu_wdata   = 64'h5555_5555_5555_5555;
    n = 0;
    vbad = 0;
    while (busy && n < 1000) begin
      @(posedge clock);
      n++;
      if (scan_valid) vbad++;
      if (n == 1) begin
        chk("clear_wr_err", 64'(cpu_err), 64'd1);
        cpu_write = 1'b0;
      end
    end
    chk("clear_cycles", 64'(n), 64'd600);
    chk("clear_no_scan", 64'(vbad), 64'd0);
    repeat (3) @(posedge clock);
    chk("clear_idle_busy", 64'(busy), 64'd0);
    chk("clear_idle_valid", 64'(scan_valid), 64'd0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      cpu_addr = 64'(i);
      @(posedge clock);
      if (cpu_rdata !== CLR) bad++;
    end
    chk("clear_sweep_bad", 64'(bad), 64'd0);
    chk("clear_last_word", cpu_rdata, CLR);

    // preload mem[i] = i
    cpu_write = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cpu_addr  = 64'(i);
      cpu_wdata = 64'(i);
      @(posedge clock);
    end
    cpu_write = 1'b0;

    // full-speed scan
    scan_ready = 1'b1;
    scan_start = 1'b1;
    @(posedge clock);
    scan_start = 1'b0;
    lat = 1;
    while (!scan_valid && lat < 10) begin
      @(posedge clock);
      lat++;
    end
    chk("first_valid_ok", 64'(lat <= 3), 64'd1);
    bad  = 0;
    bad2 = 0;
    for (int k = 0; k < 600; k++) begin
      if (!scan_valid || scan_data !== 64'(k) ||
          scan_index !== 10'(k)) bad++;
      if (scan_last !== (k == 599)) bad2++;
      @(posedge clock);
    end
    chk("full_seq_bad", 64'(bad), 64'd0);
    chk("full_last_bad", 64'(bad2), 64'd0);
    chk("full_done", 64'(frame_done), 64'd1);
    chk("full_busy", 64'(busy), 64'd0);
    chk("full_valid", 64'(scan_valid), 64'd0);
    @(posedge clock);
    chk("full_done_pulse", 64'(frame_done), 64'd0);

    // backpressure with a 5-cycle stall at index 3
    scan_ready = 1'b0;
    scan_start = 1'b1;
    @(posedge clock);
    scan_start = 1'b0;
    exp_i = 0;
    held  = 0;
    bad   = 0;
    bad2  = 0;
    n     = 0;
    while (exp_i < 600 && n < 8000) begin
      @(posedge clock);
      n++;
      if (scan_valid && scan_index == 10'd3 && held < 5) begin
        if (scan_data !== 64'd3) bad2++;
        held++;
        scan_ready = 1'b0;
      end else begin
        scan_ready = 1'($urandom_range(0, 1));
        if (scan_valid && scan_ready) begin
          if (scan_data !== 64'(exp_i) ||
              scan_index !== 10'(exp_i) ||
              scan_last !== (exp_i == 599)) bad++;
          exp_i++;
        end
      end
    end
    chk("bp_accepted", 64'(exp_i), 64'd600);
    chk("bp_seq_bad", 64'(bad), 64'd0);
    chk("bp_stall_len", 64'(held), 64'd5);
    chk("bp_stall_data", 64'(bad2), 64'd0);
    @(posedge clock);
    chk("bp_done", 64'(frame_done), 64'd1);
    chk("bp_busy", 64'(busy), 64'd0);

    // reset mid-scan
    scan_ready = 1'b1;
    scan_start = 1'b1;
    @(posedge clock);
    scan_start = 1'b0;
    n = 0;
    while (!(scan_valid && scan_index == 10'd100) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("rst_reach_100", 64'(scan_index), 64'd100);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    fd_bad = 0;
    repeat (3) begin
      @(posedge clock);
      if (frame_done) fd_bad++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock);
      if (frame_done) fd_bad++;
    end
    chk("rst_no_done", 64'(fd_bad), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);
    scan_start = 1'b1;
    @(posedge clock);
    scan_start = 1'b0;
    n = 0;
    while (!scan_valid && n < 10) begin
      @(posedge clock);
      n++;
    end
    chk("restart_valid", 64'(scan_valid), 64'd1);
    chk("restart_index", 64'(scan_index), 64'd0);
    chk("restart_data", scan_data, 64'd0);
    n = 0;
    while (!frame_done && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("restart_done", 64'(frame_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_framebuffer_stream.md
Name: gpu_framebuffer_stream

Overview:
- Parametrised successor to the GPU character framebuffer.
- Single-clock RAM of DEPTH words, DATA_WIDTH bits each, with a CPU load/store port that supports byte-enable writes and a bounds check.
- Adds a hardware clear engine and a scan-out streamer. The streamer reads the whole buffer in order over a valid/ready handshake, for the display/character-generator stage.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- DEPTH, 600, number of words (600 x 4 chars = 2400 characters).
- ADDR_WIDTH, 10, width of internal index; must satisfy 2^ADDR_WIDTH >= DEPTH.
- CLEAR_VALUE, 64'h0020_0020_0020_0020, word written by the clear engine (space characters).

Ports:
- clock  in  1  system clock; all sequential logic updates on the negative edge, matching the CPU datapath.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  64  CPU word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_write  in  1  store strobe.
- cpu_byte_en  in  DATA_WIDTH/8  per-byte write enable.
- cpu_rdata  out  DATA_WIDTH  registered load data.
- cpu_err  out  1  one-cycle pulse on a rejected access.
- clear_req  in  1  start hardware clear.
- scan_start  in  1  start one frame scan.
- busy  out  1  high while state is not IDLE.
- scan_data  out  DATA_WIDTH  streamed word.
- scan_index  out  ADDR_WIDTH  word index of scan_data.
- scan_valid  out  1  scan_data is valid.
- scan_ready  in  1  consumer accepts when valid and ready are both high.
- scan_last  out  1  qualifies the word at index DEPTH-1.
- frame_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (reset_n low, asynchronous) clears these outputs and internal state to 0: cpu_rdata, cpu_err, busy, scan_valid, scan_last, frame_done, scan_index, FIFO and counters. FSM goes to IDLE. RAM contents are not cleared. Reset asserted mid-clear or mid-scan aborts the operation immediately; no frame_done is produced.
- CPU port:
  - Read latency is 1 edge: cpu_rdata = mem[cpu_addr] sampled at that edge (read-before-write on the same address).
  - Writes merge by byte: a byte is updated only where cpu_byte_en is 1.
  - cpu_addr >= DEPTH: write dropped, cpu_rdata = 0, cpu_err pulses.
  - A write during CLEAR is dropped and cpu_err pulses. Reads during CLEAR are allowed.
  - Writes during SCAN are allowed. A word already fetched keeps its old value; a word not yet fetched returns the new value.
- FSM states: IDLE, CLEAR, SCAN.
  - IDLE -> CLEAR on clear_req. clear_req has priority if it arrives in the same cycle as scan_start; that scan_start is dropped.
  - IDLE -> SCAN on scan_start.
  - CLEAR writes CLEAR_VALUE to index 0..DEPTH-1, one word per edge (DEPTH edges), then returns to IDLE. It takes priority over a CPU write to the RAM write port.
  - SCAN -> IDLE on the edge where the word at index DEPTH-1 is accepted; frame_done pulses on the following cycle.
  - clear_req and scan_start are ignored when the state is not IDLE.
- Scan datapath:
  - A fetch counter issues RAM reads at index 0..DEPTH-1.
  - Read data lands in a 2-entry output FIFO.
  - A read issues only when (FIFO occupancy + reads in flight) < 2, so the FIFO never overflows and no word is lost or duplicated under any scan_ready pattern.
  - scan_data, scan_index and scan_last come from the FIFO head. They are held stable while scan_valid is high and scan_ready is low.
  - First scan_valid is high no later than 2 edges after the edge that samples scan_start.
  - With scan_ready held high, throughput is 1 word per cycle: DEPTH consecutive valid cycles.
  - scan_index increments by 1 per accepted word. It does not wrap past DEPTH-1.
- Width rules:
  - cpu_addr is compared against DEPTH at full 64 bits, then truncated to ADDR_WIDTH.
  - Counters are ADDR_WIDTH wide and compare against DEPTH-1.

Decomposition:
- Package gpu_fb_pkg holds:
  - FSM state enum fb_state_t (IDLE, CLEAR, SCAN).
  - Default DEPTH, DATA_WIDTH and CLEAR_VALUE constants.
  - Function bytes_merge(old, new, be).
- One sub-module, gpu_fb_skid_fifo: 2-entry valid/ready FIFO carrying {data, index, last}, with occupancy output.

Test Plan:
- Byte-enable store: write 64'h1111_2222_3333_4444 to addr 5, then 64'hFFFF_FFFF_FFFF_FFFF with be=8'h0F, read addr 5 -> 64'h1111_2222_FFFF_FFFF one edge later.
- Bounds: write to addr 600 -> cpu_err pulses 1 cycle, cpu_rdata=0; addr 599 readback unchanged.
- Clear: assert clear_req -> busy high for 600 cycles, a concurrent write to addr 10 -> cpu_err; afterwards every address reads 64'h0020_0020_0020_0020.
- Full-speed scan: preload mem[i]=i, scan_start, scan_ready=1 -> scan_data 0..599 on 600 consecutive cycles, scan_last only at index 599, frame_done 1 cycle later, busy low after.
- Backpressure: scan with scan_ready toggling randomly and held low for 5 cycles at index 3 -> scan_data=3 stable while stalled, no gaps or duplicates in the accepted sequence 0..599.
- Reset mid-scan: drop reset_n at index 100 -> all outputs 0 immediately, no frame_done; new scan_start restarts at index 0.
